// File: rtl/debug_ctrl_pkg.sv
// Shared encodings for the debug run-control sequencer: command codes,
// run-control states and the helper mapping a start command to its state.
package debug_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_HALT    = 3'd1,
    CMD_RUN     = 3'd2,
    CMD_STEP_U  = 3'd3,
    CMD_STEP_N  = 3'd4,
    CMD_SET_BP  = 3'd5,
    CMD_CLR_BP  = 3'd6,
    CMD_CLR_CNT = 3'd7
  } cmd_t;

  typedef enum logic [1:0] {
    ST_HALT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP_U = 2'd2,
    ST_STEP_N = 2'd3
  } state_t;

  // State entered when a start command is accepted while halted.
  function automatic state_t start_state(input cmd_t cmd);
    case (cmd)
      CMD_STEP_U: return ST_STEP_U;
      CMD_STEP_N: return ST_STEP_N;
      default:    return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/debug_bp_unit.sv
// Single hardware breakpoint on CP: address/enable registers written by
// SET_BP / CLR_BP and a full-width equality comparator.
module debug_bp_unit
  import debug_ctrl_pkg::*;
#(
  parameter int p_data_width = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  input  logic [2:0]              cmd,
  input  logic [p_data_width-1:0] cmd_data,
  input  logic [p_data_width-1:0] cp,
  output logic                    bp_match
);

  logic                    bp_en;
  logic [p_data_width-1:0] bp_addr;

  // Breakpoint registers: SET_BP arms and loads the address, CLR_BP disarms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_en   <= 1'b0;
      bp_addr <= '0;
    end else if (cmd_valid) begin
      if (cmd_t'(cmd) == CMD_SET_BP) begin
        bp_en   <= 1'b1;
        bp_addr <= cmd_data;
      end else if (cmd_t'(cmd) == CMD_CLR_BP) begin
        bp_en <= 1'b0;
      end
    end
  end

  assign bp_match = bp_en & (cp == bp_addr);

endmodule

// File: rtl/debug_ctrl.sv
// Debug run-control sequencer: owns the CPU clock enable and implements
// halt / run / micro-step / instruction-step, one CP breakpoint and an
// enabled-cycle counter. The breakpoint hardware is present only when the
// macro DEBUG_CTRL_BP_EN is defined; otherwise SET_BP/CLR_BP are rejected.
//
// Command channel: a command transfers on every cycle with
// i_w_cmd_valid=1; o_w_cmd_ready is constant 1, so there is no back-pressure.
module debug_ctrl
  import debug_ctrl_pkg::*;
#(
  parameter int p_data_width  = 16,
  parameter int p_step_width  = 8,
  parameter int p_count_width = 32
) (
  input  logic                     i_w_clk,
  input  logic                     i_w_reset,
  input  logic                     i_w_cmd_valid,
  output logic                     o_w_cmd_ready,
  input  logic [2:0]               i_w_cmd,
  input  logic [p_data_width-1:0]  i_w_cmd_data,
  input  logic [p_data_width-1:0]  i_w_cp,
  input  logic                     i_w_instr_boundary,
  output logic                     o_w_cpu_en,
  output logic                     o_w_halted,
  output logic                     o_w_bp_hit,
  output logic                     o_w_cmd_err,
  output logic [p_count_width-1:0] o_w_cycle_count,
  output logic [1:0]               o_w_state
);

  localparam logic [p_step_width-1:0]  STEP_ONE  = 1;
  localparam logic [p_count_width-1:0] COUNT_ONE = 1;
`ifdef DEBUG_CTRL_BP_EN
  localparam logic BP_PRESENT = 1'b1;
`else
  localparam logic BP_PRESENT = 1'b0;
`endif

  state_t                   state, state_nxt;
  logic                     skip, skip_nxt;
  logic [p_step_width-1:0]  remaining, remaining_nxt;
  logic [p_step_width-1:0]  step_n;
  logic                     bp_hit, bp_hit_nxt;
  logic                     cmd_err, cmd_err_nxt;
  logic [p_count_width-1:0] count;
  logic                     bp_match;
  logic                     stop;
  logic                     cpu_en;
  cmd_t                     cmd;

  assign cmd    = cmd_t'(i_w_cmd);
  assign step_n = i_w_cmd_data[p_step_width-1:0];

`ifdef DEBUG_CTRL_BP_EN
  debug_bp_unit #(
    .p_data_width(p_data_width)
  ) u_bp (
    .clk      (i_w_clk),
    .rst_n    (i_w_reset),
    .cmd_valid(i_w_cmd_valid),
    .cmd      (i_w_cmd),
    .cmd_data (i_w_cmd_data),
    .cp       (i_w_cp),
    .bp_match (bp_match)
  );
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{i_w_cp, i_w_cmd_data};
  assign bp_match         = 1'b0;
`endif

  // Stop condition: evaluated at instruction boundaries, suppressed on the
  // instruction the CPU resumed from (skip).
  always_comb begin
    stop = 1'b0;
    case (state)
      ST_RUN:    stop = i_w_instr_boundary & bp_match & ~skip;
      ST_STEP_N: stop = i_w_instr_boundary & ~skip &
                        ((remaining == '0) | bp_match);
      default:   stop = 1'b0;
    endcase
  end

  assign cpu_en = (state != ST_HALT) & ~stop;

  // Next-state and bookkeeping; command decode last so HALT overrides all.
  always_comb begin
    state_nxt     = state;
    skip_nxt      = skip;
    remaining_nxt = remaining;
    bp_hit_nxt    = bp_hit;
    cmd_err_nxt   = 1'b0;

    if (cpu_en) skip_nxt = 1'b0;
    if (cpu_en && state == ST_STEP_N && i_w_instr_boundary && !skip &&
        remaining != '0)
      remaining_nxt = remaining - STEP_ONE;
    if (state == ST_STEP_U) state_nxt = ST_HALT;
    if (stop) begin
      state_nxt = ST_HALT;
      if (bp_match) bp_hit_nxt = 1'b1;
    end

    if (i_w_cmd_valid) begin
      case (cmd)
        CMD_HALT: state_nxt = ST_HALT;
        CMD_RUN, CMD_STEP_U, CMD_STEP_N: begin
          if (state == ST_HALT) begin
            state_nxt  = start_state(cmd);
            skip_nxt   = i_w_instr_boundary;
            bp_hit_nxt = 1'b0;
            if (cmd == CMD_STEP_N)
              remaining_nxt = (step_n == '0) ? '0 : step_n - STEP_ONE;
          end else begin
            cmd_err_nxt = 1'b1;
          end
        end
        CMD_SET_BP, CMD_CLR_BP: cmd_err_nxt = ~BP_PRESENT;
        default: ;
      endcase
    end
  end

  // Run-control state registers.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      state     <= ST_HALT;
      skip      <= 1'b0;
      remaining <= '0;
      bp_hit    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      skip      <= skip_nxt;
      remaining <= remaining_nxt;
      bp_hit    <= bp_hit_nxt;
      cmd_err   <= cmd_err_nxt;
    end
  end

  // Enabled-cycle counter; CLR_CNT wins over the increment.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset)
      count <= '0;
    else if (i_w_cmd_valid && cmd == CMD_CLR_CNT)
      count <= '0;
    else if (cpu_en)
      count <= count + COUNT_ONE;
  end

  assign o_w_cmd_ready   = 1'b1;
  assign o_w_cpu_en      = cpu_en;
  assign o_w_halted      = (state == ST_HALT);
  assign o_w_bp_hit      = bp_hit & BP_PRESENT;
  assign o_w_cmd_err     = cmd_err;
  assign o_w_cycle_count = count;
  assign o_w_state       = state;

endmodule

// File: tb/tb_debug_ctrl.sv
// Bench for debug_ctrl. A small fake microcoded CPU (instructions of 1..3
// micro-cycles, CP advancing by 4) feeds CP and the boundary flag; a
// behavioural run-control model predicts every output.
module tb_debug_ctrl;

  localparam logic [2:0] C_NOP = 3'd0, C_HALT = 3'd1, C_RUN = 3'd2,
                         C_STEP_U = 3'd3, C_STEP_N = 3'd4, C_SET_BP = 3'd5,
                         C_CLR_BP = 3'd6, C_CLR_CNT = 3'd7;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP_U = 2, M_STEP_N = 3;
`ifdef DEBUG_CTRL_BP_EN
  localparam bit BP_FEAT = 1'b1;
`else
  localparam bit BP_FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd = 3'd0;
  logic [15:0] cmd_data = 16'd0;
  logic [15:0] cp = 16'd0;
  logic        boundary = 1'b1;
  logic        cpu_en, halted, bp_hit, cmd_err;
  logic [31:0] cycle_count;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int          m_mode;
  bit          m_skip, m_hit, m_err, m_bp_en;
  int          m_rem;
  logic [15:0] m_bp_addr;
  logic [31:0] m_count;
  bit          m_match, m_stop, m_en;
  // fake CPU
  logic [15:0] cpu_cp;
  int          cpu_idx;

  always #5 clk = ~clk;

  debug_ctrl dut (
    .i_w_clk           (clk),
    .i_w_reset         (rst_n),
    .i_w_cmd_valid     (cmd_valid),
    .o_w_cmd_ready     (cmd_ready),
    .i_w_cmd           (cmd),
    .i_w_cmd_data      (cmd_data),
    .i_w_cp            (cp),
    .i_w_instr_boundary(boundary),
    .o_w_cpu_en        (cpu_en),
    .o_w_halted        (halted),
    .o_w_bp_hit        (bp_hit),
    .o_w_cmd_err       (cmd_err),
    .o_w_cycle_count   (cycle_count),
    .o_w_state         (state_dbg)
  );

  function automatic int ilen(input logic [15:0] a);
    return int'((a >> 2) % 16'd3) + 1;
  endfunction

  task automatic model_reset();
    m_mode = M_HALT; m_skip = 0; m_hit = 0; m_err = 0; m_bp_en = 0;
    m_rem = 0; m_bp_addr = 16'd0; m_count = 32'd0;
    cpu_cp = 16'd0; cpu_idx = 0;
  endtask

  // Apply inputs for this cycle and predict the combinational outputs.
  task automatic drive(input logic v, input logic [2:0] c, input logic [15:0] d);
    cmd_valid = v; cmd = c; cmd_data = d;
    cp = cpu_cp; boundary = (cpu_idx == 0);
    #1;
    m_match = BP_FEAT && m_bp_en && (cpu_cp == m_bp_addr);
    m_stop  = 0;
    if (m_mode == M_RUN)    m_stop = boundary && m_match && !m_skip;
    if (m_mode == M_STEP_N) m_stop = boundary && !m_skip && (m_rem == 0 || m_match);
    m_en = (m_mode != M_HALT) && !m_stop;
  endtask

  // Commit the cycle in the model and the fake CPU, then move to next cycle.
  task automatic advance();
    int n_mode = m_mode;
    int n_rem = m_rem;
    bit n_skip = m_skip, n_hit = m_hit, n_err = 0;
    logic [31:0] n_count = m_count;
    int n = int'(cmd_data[7:0]);
    if (m_en) begin n_skip = 0; n_count = m_count + 32'd1; end
    if (m_en && m_mode == M_STEP_N && boundary && !m_skip && m_rem != 0) n_rem = m_rem - 1;
    if (m_mode == M_STEP_U) n_mode = M_HALT;
    if (m_stop) begin n_mode = M_HALT; if (m_match) n_hit = 1; end
    if (cmd_valid) begin
      case (cmd)
        C_HALT: n_mode = M_HALT;
        C_RUN, C_STEP_U, C_STEP_N: begin
          if (m_mode == M_HALT) begin
            n_mode = (cmd == C_RUN) ? M_RUN : (cmd == C_STEP_U) ? M_STEP_U : M_STEP_N;
            n_skip = boundary; n_hit = 0;
            if (cmd == C_STEP_N) n_rem = (n == 0) ? 0 : n - 1;
          end else n_err = 1;
        end
        C_SET_BP: if (BP_FEAT) begin m_bp_en = 1; m_bp_addr = cmd_data; end else n_err = 1;
        C_CLR_BP: if (BP_FEAT) m_bp_en = 0; else n_err = 1;
        C_CLR_CNT: n_count = 32'd0;
        default: ;
      endcase
    end
    if (m_en) begin
      if (cpu_idx == ilen(cpu_cp) - 1) begin cpu_idx = 0; cpu_cp = cpu_cp + 16'd4; end
      else cpu_idx = cpu_idx + 1;
    end
    m_mode = n_mode; m_rem = n_rem; m_skip = n_skip; m_hit = n_hit;
    m_err = n_err; m_count = n_count;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_en got %b want 0", cpu_en); end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL reset_halted got %b want 1", halted); end
    vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", cycle_count); end
    vectors++; if (bp_hit !== 1'b0 || cmd_err !== 1'b0) begin miscompares++; $display("FAIL reset_flags got hit=%b err=%b want 0 0", bp_hit, cmd_err); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    drive(0, C_NOP, 16'd0);
    vectors++; if (cpu_en !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("FAIL release_idle got en=%b halted=%b want 0 1", cpu_en, halted); end
    advance();
  endtask

  task automatic test_run_halt();
    drive(1, C_RUN, 16'd0);
    vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL run_accept_en got %b want 0", cpu_en); end
    advance();
    for (int i = 0; i < 10; i++) begin
      drive(0, C_NOP, 16'd0);
      vectors++; if (cpu_en !== 1'b1) begin miscompares++; $display("FAIL run_en cyc %0d got %b want 1", i, cpu_en); end
      advance();
    end
    drive(1, C_HALT, 16'd0);
    vectors++; if (cycle_count !== 32'd10) begin miscompares++; $display("FAIL run_count got %0d want 10", cycle_count); end
    vectors++; if (cpu_en !== 1'b1) begin miscompares++; $display("FAIL halt_accept_en got %b want 1", cpu_en); end
    advance();
    drive(0, C_NOP, 16'd0);
    vectors++; if (cpu_en !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("FAIL halted got en=%b halted=%b want 0 1", cpu_en, halted); end
    advance();
  endtask

  task automatic test_step_u();
    drive(1, C_STEP_U, 16'd0);
    advance();
    drive(0, C_NOP, 16'd0);
    vectors++; if (cpu_en !== 1'b1) begin miscompares++; $display("FAIL step_u_en got %b want 1", cpu_en); end
    advance();
    drive(0, C_NOP, 16'd0);
    vectors++; if (cpu_en !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("FAIL step_u_stop got en=%b halted=%b want 0 1", cpu_en, halted); end
    vectors++; if (cycle_count !== 32'd12) begin miscompares++; $display("FAIL step_u_count got %0d want 12", cycle_count); end
    advance();
  endtask

  task automatic test_step_n();
    logic [15:0] d [3] = '{16'h0001, 16'h0003, 16'hAB00};
    logic [31:0] want [3] = '{32'd1, 32'd7, 32'd9};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, C_STEP_N, d[k]);
      advance();
      for (int i = 0; i < 12; i++) begin
        drive(0, C_NOP, 16'd0);
        vectors++; if (cpu_en !== m_en) begin miscompares++; $display("FAIL step_n%0d_en cyc %0d got %b want %b", k, i, cpu_en, m_en); end
        advance();
      end
      drive(0, C_NOP, 16'd0);
      vectors++; if (halted !== 1'b1 || cycle_count !== want[k]) begin miscompares++; $display("FAIL step_n%0d_end got halted=%b count=%0d want 1 %0d", k, halted, cycle_count, want[k]); end
      advance();
    end
  endtask

  task automatic test_breakpoint();
    do_reset();
    drive(1, C_SET_BP, 16'h0010);
    advance();
    drive(0, C_NOP, 16'd0);
    vectors++; if (cmd_err !== !BP_FEAT) begin miscompares++; $display("FAIL set_bp_err got %b want %b", cmd_err, !BP_FEAT); end
    advance();
    for (int r = 0; r < 2; r++) begin
      drive(1, C_RUN, 16'd0);
      advance();
      for (int i = 0; i < 15; i++) begin
        drive(0, C_NOP, 16'd0);
        vectors++; if (cpu_en !== m_en || halted !== (m_mode == M_HALT) || bp_hit !== m_hit) begin
          miscompares++; $display("FAIL bp_run%0d cyc %0d got en=%b halted=%b hit=%b want %b %b %b", r, i, cpu_en, halted, bp_hit, m_en, m_mode == M_HALT, m_hit);
        end
        advance();
      end
      drive(0, C_NOP, 16'd0);
      vectors++; if (bp_hit !== (BP_FEAT && r == 0)) begin miscompares++; $display("FAIL bp_hit_run%0d got %b want %b", r, bp_hit, BP_FEAT && r == 0); end
      advance();
      drive(1, C_HALT, 16'd0);
      advance();
    end
  endtask

  task automatic test_cmd_err();
    bit injected = 0;
    do_reset();
    drive(1, C_RUN, 16'd0); advance();
    for (int i = 0; i < 3; i++) begin drive(0, C_NOP, 16'd0); advance(); end
    drive(1, C_RUN, 16'd0); advance();
    drive(0, C_NOP, 16'd0);
    vectors++; if (cmd_err !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("FAIL run_while_running got err=%b halted=%b want 1 0", cmd_err, halted); end
    advance();
    drive(0, C_NOP, 16'd0);
    vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL err_pulse_width got %b want 0", cmd_err); end
    advance();
    drive(1, C_HALT, 16'd0); advance();
    drive(1, C_STEP_N, 16'h0001); advance();
    for (int i = 0; i < 10 && !injected; i++) begin
      drive(0, C_NOP, 16'd0);
      if (m_stop) begin
        drive(1, C_HALT, 16'd0);
        injected = 1;
        vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL halt_and_stop_en got %b want 0", cpu_en); end
      end
      advance();
    end
    drive(0, C_NOP, 16'd0);
    vectors++; if (halted !== 1'b1 || cycle_count !== m_count) begin miscompares++; $display("FAIL halt_and_stop got halted=%b count=%0d want 1 %0d", halted, cycle_count, m_count); end
    advance();
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [2:0]  c;
    logic        v;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) == 0);
      c = 3'($urandom_range(0, 7));
      d = 16'($urandom);
      if (c == C_STEP_N) d[7:0] = 8'($urandom_range(0, 4));
      if (c == C_SET_BP) d = 16'(4 * $urandom_range(2, 60));
      drive(v, c, d);
      vectors++; if (cpu_en !== m_en || halted !== (m_mode == M_HALT) || bp_hit !== m_hit ||
                     cmd_err !== m_err || cycle_count !== m_count || cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL random cyc %0d got en=%b halted=%b hit=%b err=%b cnt=%0d want %b %b %b %b %0d",
                 i, cpu_en, halted, bp_hit, cmd_err, cycle_count, m_en, m_mode == M_HALT, m_hit, m_err, m_count);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, C_SET_BP, 16'h0010); advance();
    drive(1, C_RUN, 16'd0); advance();
    for (int i = 0; i < 3; i++) begin drive(0, C_NOP, 16'd0); advance(); end
    drive(0, C_NOP, 16'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++; if (cpu_en !== 1'b0 || halted !== 1'b1 || cycle_count !== 32'd0) begin
      miscompares++; $display("FAIL async_reset got en=%b halted=%b cnt=%0d want 0 1 0", cpu_en, halted, cycle_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, C_RUN, 16'd0); advance();
    for (int i = 0; i < 20; i++) begin
      drive(0, C_NOP, 16'd0);
      vectors++; if (cpu_en !== 1'b1 || bp_hit !== 1'b0) begin miscompares++; $display("FAIL bp_cleared cyc %0d got en=%b hit=%b want 1 0", i, cpu_en, bp_hit); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_step_u();
    test_step_n();
    test_breakpoint();
    test_cmd_err();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_ctrl.md
Name: debug_ctrl

Overview:
Run-control sequencer for the microprogrammed CPU in debug mode. It owns the single clock-enable that gates the command unit (uc) and every datapath register, so the CPU can halt, run, single-step microinstructions, or step N instructions. It also supports one hardware breakpoint on CP and counts enabled cycles. Commands arrive on a valid/ready port from the board-level debug front end.

Parameters:
p_data_width, 16, width of CP and command data
p_step_width, 8, width of the instruction step count
p_count_width, 32, width of the enabled-cycle counter

Ports:
i_w_clk  input  1  system clock
i_w_reset  input  1  asynchronous, active-low reset
i_w_cmd_valid  input  1  command valid
o_w_cmd_ready  output  1  always 1; every command is accepted in one cycle
i_w_cmd  input  3  0 NOP, 1 HALT, 2 RUN, 3 STEP_U, 4 STEP_N, 5 SET_BP, 6 CLR_BP, 7 CLR_CNT
i_w_cmd_data  input  p_data_width  breakpoint address (SET_BP); step count in [p_step_width-1:0] (STEP_N)
i_w_cp  input  p_data_width  current CP value (display output of CP)
i_w_instr_boundary  input  1  from uc; high while the next enabled edge starts a new instruction fetch; CP then holds that instruction's address
o_w_cpu_en  output  1  clock enable for uc and all datapath registers
o_w_halted  output  1  state == HALT
o_w_bp_hit  output  1  sticky: last stop was caused by the breakpoint
o_w_cmd_err  output  1  one-cycle pulse when an illegal command is dropped
o_w_cycle_count  output  p_count_width  number of enabled cycles

Behaviour:
- Reset (async, i_w_reset=0): state HALT, cpu_en 0 immediately, bp_en 0, bp_addr 0, bp_hit 0, cmd_err 0, count 0, remaining 0, skip 0.
- States: HALT, RUN, STEP_U, STEP_N.
- A command is accepted when cmd_valid=1. Its effect is registered and visible the next cycle.
- Combinational output: cpu_en = (state != HALT) & ~stop, where stop is:
  - RUN: boundary & bp_match & ~skip.
  - STEP_N: boundary & ~skip & (remaining==0 | bp_match).
  - STEP_U: never.
- bp_match = bp_en & (i_w_cp == bp_addr). The match is full-width.
- HALT accepts RUN, STEP_U, STEP_N. It loads skip <= i_w_instr_boundary, clears bp_hit, and enters the requested state.
- STEP_N loads remaining <= N-1. N=0 is treated as 1.
- RUN, STEP_U and STEP_N received in a non-HALT state are dropped with cmd_err.
- HALT is accepted in any state: next state HALT. The acceptance cycle itself is still enabled, so the CPU may stop mid-instruction.
- SET_BP, CLR_BP and CLR_CNT are legal in any state and never change state.
- skip clears after the first enabled cycle. It prevents re-hitting the breakpoint, or re-counting, at the instruction the CPU resumed from.
- STEP_N: at each enabled boundary with skip=0 and remaining != 0, decrement remaining.
- STEP_U: exactly one enabled cycle, then HALT.
- When stop is asserted: next state HALT. If the cause is bp_match, set bp_hit. The stopping cycle is not enabled and not counted.
- Simultaneous HALT command and stop: HALT. bp_hit is still set if bp_match caused the stop.
- Cycle count increments when cpu_en=1 and wraps modulo 2^p_count_width. CLR_CNT takes priority over the increment.

Optional Feature:
DEBUG_CTRL_BP_EN
- Defined: breakpoint logic is present as specified.
- Undefined: bp_match is constant 0 and o_w_bp_hit is tied 0. SET_BP and CLR_BP are dropped with a cmd_err pulse.

Decomposition:
- debug_ctrl_pkg holds the command encodings (CMD_NOP..CMD_CLR_CNT) and the state encodings (ST_HALT, ST_RUN, ST_STEP_U, ST_STEP_N).
- One sub-module, debug_bp_unit: bp_addr/bp_en registers, SET/CLR handling, and the bp_match comparator. It is instantiated only under DEBUG_CTRL_BP_EN.

Test Plan:
- Reset release: cpu_en=0, halted=1, count=0. Then RUN: cpu_en=1 from the next cycle; after 10 cycles count=10; HALT: cpu_en=0 the following cycle.
- STEP_U from HALT: exactly one cycle with cpu_en=1, then halted=1; count increments by 1.
- Halted at a boundary with CP=0x0004, STEP_N with data=3: three instructions execute; the CPU stops with cpu_en=0 at the 4th boundary. data=0 behaves like data=1.
- SET_BP 0x0010, then RUN: the CPU stops at the boundary where CP=0x0010 and bp_hit=1. A second RUN resumes past 0x0010 (skip) and clears bp_hit.
- RUN while running gives a cmd_err pulse with no state change. HALT and stop in the same cycle give HALT.
- Assert reset mid-RUN: cpu_en drops asynchronously. After release: HALT, count=0, breakpoint disabled.
